gshare_direction_predictor: RTL and testbench
=============================================

# gshare_direction_predictor

Global-history (gshare) direction predictor for the two-bit global-prediction fetch path. It sits beside the branch target buffer in IF and supplies the taken/not-taken counter used to qualify BTB hits on conditional branches. It tracks a speculative global history register (GHR) and carries each fetched branch's table index and history snapshot down to EX. At EX it trains the pattern history table (PHT) and repairs the GHR on misprediction.

## Interface
- GHR_BITS, 5, history length; PHT has 2^GHR_BITS two-bit counters
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low (asserted when 0)
- current_pc  input  32  PC being fetched this cycle
- fetch_is_branch  input  1  BTB reports a valid conditional-branch hit for current_pc
- IF_ID_write  input  1  0 = pipeline stall: IF/ID holds, bubble into ID/EX
- is_flush  input  1  BTB misprediction flush from EX
- ID_EX_is_branch  input  1  instruction in EX is a conditional branch
- EX_alu_bcond  input  1  resolved branch outcome in EX
- current_counter  output  2  PHT counter at fetch index (combinational)
- pred_taken  output  1  current_counter[1]
- ghr  output  GHR_BITS  current speculative history (debug)

## Operation
- Fetch index: fidx = current_pc[GHR_BITS+1:2] ^ ghr. current_counter = pht[fidx] (combinational, pre-update value; no bypass of same-cycle write).
- Shadow pipeline: two registers, IF_ID_snap and ID_EX_snap, each holding {valid, idx, ghr_before, shifted}.
  - Fetch-side write (when IF_ID_write=1 and is_flush=0): IF_ID_snap <= {1, fidx, ghr, fetch_is_branch}.
  - ID/EX advance: ID_EX_snap <= IF_ID_snap when IF_ID_write=1; valid=0 bubble when IF_ID_write=0.
  - is_flush=1: both snaps' valid <= 0. Flush has priority over stall.
- Resolution fires when ID_EX_is_branch=1 and ID_EX_snap.valid=1.
  - PHT train: pht[ID_EX_snap.idx] saturating +1 if EX_alu_bcond, else saturating -1. Range is 0..3; no wrap.
  - Non-resolving branches in EX (valid=0, or not a branch) leave the PHT untouched.
- GHR next-state, in priority order:
  1. Resolution with (is_flush=1 or ID_EX_snap.shifted=0): ghr <= {ID_EX_snap.ghr_before[GHR_BITS-2:0], EX_alu_bcond}.
  2. Else, fetch_is_branch=1 and IF_ID_write=1 and is_flush=0: ghr <= {ghr[GHR_BITS-2:0], pred_taken}.
  3. Else, is_flush=1 without resolution (jal/jalr flush): ghr holds.
  4. Otherwise ghr holds.
- Repair of younger in-flight snapshots is not performed. A squashed fetch never shifts the GHR.

## Timing
- Reset (reset=0, asynchronous, takes effect immediately, mid-cycle included):
  - all PHT counters = 2'b01 (weakly not-taken)
  - ghr = 0
  - both snaps invalid and zeroed
  - therefore current_counter=2'b01, pred_taken=0 while reset is held
- Prediction latency is 0 cycles: outputs are valid in the same cycle as current_pc.
- Updates become visible at the next rising edge:
  - PHT write and GHR update occur on the edge ending the resolution cycle.
  - A fetch in the same cycle reading the same PHT entry sees the old value.
- Branch life: fetch cycle N → IF_ID_snap at edge N → ID_EX_snap at edge N+1 → resolves in cycle N+2 (no stalls). Each stall cycle adds one cycle.
- Simultaneous events:
  - resolution + fetch shift in the same cycle (no flush): rule 2 applies only when rule 1 did not fire.
  - resolution repair always wins.

## Test plan
- Reset: drive reset=0 mid-run with nonzero ghr → ghr=0, current_counter=2'b01 immediately. Release, fetch PC 0x10 → fidx=4, pred_taken=0.
- Saturation: resolve the same branch (idx 4) taken 4 times with no flush → counter 01→10→11→11. Then 3 not-taken → 10→01→00, stays 00.
- Index hashing: ghr=5'b00110, current_pc=0x10 → fidx=5'b00010. current_counter reflects pht[2], not pht[4].
- Speculative shift and repair:
  - fetch branch with pred_taken=1, ghr=5'b00001 → ghr=5'b00011.
  - two cycles later resolve not-taken with is_flush=1 → ghr=5'b00010.
  - the same-cycle fetch shift is suppressed.
- Stall/flush: IF_ID_write=0 for 2 cycles → IF_ID_snap unchanged, ID_EX valid=0, no PHT write even with ID_EX_is_branch=1. is_flush=1 with IF_ID_write=0 → both snaps invalid.
- Read/write collision: resolve idx 4 taken (01→10) while fetching fidx=4 → current_counter=01 that cycle, 10 the next.

Source files
------------

// File: rtl/gshare_direction_predictor.sv
// ---------------------------------------------------------------------------
// gshare_direction_predictor
//
// Global-history (gshare) direction predictor for the IF stage. Reads a
// two-bit counter from the pattern history table (PHT) at an index formed by
// XOR-ing PC bits with the speculative global history register (GHR). Each
// fetch leaves a snapshot {valid, idx, ghr_before, shifted} that travels
// IF/ID -> ID/EX alongside the instruction. In EX the snapshot is used to
// train the PHT and, when needed, to rebuild the GHR from the known-good
// history plus the real outcome.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous reset, active-low
//   current_pc       PC fetched this cycle
//   fetch_is_branch  BTB hit on a conditional branch for current_pc
//   IF_ID_write      0 = stall: IF/ID holds, bubble into ID/EX
//   is_flush         misprediction flush from EX
//   ID_EX_is_branch  instruction in EX is a conditional branch
//   EX_alu_bcond     resolved branch outcome in EX
//   current_counter  PHT counter at the fetch index (combinational)
//   pred_taken       current_counter[1]
//   ghr              speculative global history (debug visibility)
// ---------------------------------------------------------------------------
module gshare_direction_predictor #(
    parameter int GHR_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         current_pc,
    input  logic                fetch_is_branch,
    input  logic                IF_ID_write,
    input  logic                is_flush,
    input  logic                ID_EX_is_branch,
    input  logic                EX_alu_bcond,
    output logic [1:0]          current_counter,
    output logic                pred_taken,
    output logic [GHR_BITS-1:0] ghr
);

    localparam int PHT_SIZE = 1 << GHR_BITS;

    // Snapshot handshake: a snapshot is meaningful only while valid=1. valid
    // is set by a fetch-side write, follows the instruction down the shadow
    // pipeline, and is dropped by a stall bubble (ID/EX) or any flush (both).
    // A resolution consumes the ID/EX snapshot only when it is valid and EX
    // reports a conditional branch; there is no backpressure on this path.
    typedef struct packed {
        logic                valid;
        logic [GHR_BITS-1:0] idx;
        logic [GHR_BITS-1:0] ghr_before;
        logic                shifted;
    } snap_t;

    logic [1:0]          pht [PHT_SIZE];
    snap_t               if_id_snap;
    snap_t               id_ex_snap;

    logic [GHR_BITS-1:0] fidx;
    logic                fetch_ok;
    logic                resolve;
    logic                repair;
    logic [1:0]          train_cnt;
    logic [GHR_BITS-1:0] ghr_next;

    // Only the index bits of the PC take part in the hash.
    logic                unused_pc_bits;
    assign unused_pc_bits = ^{current_pc[31:GHR_BITS+2], current_pc[1:0]};

    assign fidx            = current_pc[GHR_BITS+1:2] ^ ghr;
    assign current_counter = pht[fidx];
    assign pred_taken      = current_counter[1];

    // A fetch is only recorded (and only shifts history) when it actually
    // enters IF/ID: not stalled and not squashed by a flush.
    assign fetch_ok = IF_ID_write & ~is_flush;
    assign resolve  = ID_EX_is_branch & id_ex_snap.valid;
    // Rebuild history when the branch was flushed, or when it never shifted
    // the GHR at fetch (BTB miss) and so its outcome is not yet in history.
    assign repair   = resolve & (is_flush | ~id_ex_snap.shifted);

    always_comb begin
        train_cnt = pht[id_ex_snap.idx];
        if (EX_alu_bcond) begin
            if (train_cnt != 2'b11) begin
                train_cnt = train_cnt + 2'b01;
            end
        end else begin
            if (train_cnt != 2'b00) begin
                train_cnt = train_cnt - 2'b01;
            end
        end
    end

    always_comb begin
        ghr_next = ghr;
        if (repair) begin
            ghr_next = {id_ex_snap.ghr_before[GHR_BITS-2:0], EX_alu_bcond};
        end else if (fetch_is_branch && fetch_ok) begin
            ghr_next = {ghr[GHR_BITS-2:0], pred_taken};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pht <= '{default: 2'b01};
        end else if (resolve) begin
            pht[id_ex_snap.idx] <= train_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr <= '0;
        end else begin
            ghr <= ghr_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_id_snap <= '0;
            id_ex_snap <= '0;
        end else if (is_flush) begin
            // Flush outranks stall: everything younger than EX is squashed.
            if_id_snap <= '0;
            id_ex_snap <= '0;
        end else if (IF_ID_write) begin
            if_id_snap <= '{valid: 1'b1, idx: fidx, ghr_before: ghr,
                            shifted: fetch_is_branch};
            id_ex_snap <= if_id_snap;
        end else begin
            // Stall: IF/ID holds its snapshot, ID/EX receives a bubble.
            id_ex_snap <= '0;
        end
    end

endmodule

// File: tb/tb_gshare_direction_predictor.sv
// ---------------------------------------------------------------------------
// tb_gshare_direction_predictor
//
// Directed bench for gshare_direction_predictor (GHR_BITS = 5). Each vector
// drives one cycle of inputs at the falling edge and checks current_counter,
// pred_taken and ghr shortly after, before the next rising edge. Expected
// values are hand-derived, cycle by cycle, from the predictor's behaviour.
// ---------------------------------------------------------------------------
module tb_gshare_direction_predictor;

    typedef struct {
        logic [31:0] pc;
        logic        fib;
        logic        ifw;
        logic        fl;
        logic        exb;
        logic        bc;
        logic [1:0]  exp_cnt;
        logic [4:0]  exp_ghr;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        reset;
    logic [31:0] current_pc;
    logic        fetch_is_branch;
    logic        IF_ID_write;
    logic        is_flush;
    logic        ID_EX_is_branch;
    logic        EX_alu_bcond;
    logic [1:0]  current_counter;
    logic        pred_taken;
    logic [4:0]  ghr;

    int n_vec;
    int n_bad;

    vec_t tab_sat [13];
    vec_t tab_rep [8];
    vec_t tab_stl [9];
    vec_t tab_col [6];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    gshare_direction_predictor #(.GHR_BITS(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .current_pc      (current_pc),
        .fetch_is_branch (fetch_is_branch),
        .IF_ID_write     (IF_ID_write),
        .is_flush        (is_flush),
        .ID_EX_is_branch (ID_EX_is_branch),
        .EX_alu_bcond    (EX_alu_bcond),
        .current_counter (current_counter),
        .pred_taken      (pred_taken),
        .ghr             (ghr)
    );

    function automatic vec_t mk(input logic [31:0] pc, input logic fib,
                                input logic ifw, input logic fl,
                                input logic exb, input logic bc,
                                input logic [1:0] c, input logic [4:0] g);
        vec_t v;
        v.pc = pc; v.fib = fib; v.ifw = ifw; v.fl = fl;
        v.exb = exb; v.bc = bc; v.exp_cnt = c; v.exp_ghr = g;
        return v;
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [1:0] ec,
                         input logic [4:0] eg);
        n_vec++;
        if (current_counter !== ec || pred_taken !== ec[1] || ghr !== eg) begin
            n_bad++;
            $display("FAIL %s: got counter=%b pred=%b ghr=%b, want counter=%b pred=%b ghr=%b",
                     tag, current_counter, pred_taken, ghr, ec, ec[1], eg);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive_idle();
        current_pc      = 32'h0;
        fetch_is_branch = 1'b0;
        IF_ID_write     = 1'b0;
        is_flush        = 1'b0;
        ID_EX_is_branch = 1'b0;
        EX_alu_bcond    = 1'b0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        current_pc      = v.pc;
        fetch_is_branch = v.fib;
        IF_ID_write     = v.ifw;
        is_flush        = v.fl;
        ID_EX_is_branch = v.exb;
        EX_alu_bcond    = v.bc;
        #2;
        check(tag, v.exp_cnt, v.exp_ghr);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        drive_idle();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;

        //                 pc     fib ifw fl exb bc  cnt    ghr
        // Saturation on idx 4 (4 taken, then not-taken down to 00), then
        // the hashing check: ghr=00110, pc=0x10 -> fidx 2, not 4.
        tab_sat[0]  = mk(32'h10, 0, 1, 0, 0, 0, 2'b01, 5'd0);
        tab_sat[1]  = mk(32'h10, 0, 1, 0, 0, 0, 2'b01, 5'd0);
        tab_sat[2]  = mk(32'h14, 0, 1, 0, 1, 1, 2'b01, 5'd0);
        tab_sat[3]  = mk(32'h14, 0, 1, 0, 1, 1, 2'b10, 5'd1);
        tab_sat[4]  = mk(32'h14, 0, 1, 0, 0, 0, 2'b11, 5'd1);
        tab_sat[5]  = mk(32'h14, 0, 1, 0, 1, 1, 2'b11, 5'd1);
        tab_sat[6]  = mk(32'h1C, 0, 1, 0, 1, 1, 2'b11, 5'd3);
        tab_sat[7]  = mk(32'h1C, 0, 1, 0, 1, 0, 2'b11, 5'd3);
        tab_sat[8]  = mk(32'h18, 0, 1, 0, 1, 0, 2'b10, 5'd2);
        tab_sat[9]  = mk(32'h08, 0, 1, 0, 1, 0, 2'b01, 5'd6);
        tab_sat[10] = mk(32'h10, 0, 1, 0, 1, 0, 2'b01, 5'd6);
        tab_sat[11] = mk(32'h00, 0, 1, 0, 0, 0, 2'b00, 5'd4);
        tab_sat[12] = mk(32'h00, 0, 1, 0, 0, 0, 2'b00, 5'd4);

        // Speculative shift (ghr 00001 -> 00011) and flush repair to 00010
        // with the same-cycle fetch shift suppressed.
        tab_rep[0]  = mk(32'h00, 0, 1, 0, 0, 0, 2'b01, 5'd0);
        tab_rep[1]  = mk(32'h00, 0, 1, 0, 0, 0, 2'b01, 5'd0);
        tab_rep[2]  = mk(32'h00, 0, 1, 0, 1, 1, 2'b01, 5'd0);
        tab_rep[3]  = mk(32'h04, 1, 1, 0, 0, 0, 2'b10, 5'd1);
        tab_rep[4]  = mk(32'h00, 0, 1, 0, 0, 0, 2'b01, 5'd3);
        tab_rep[5]  = mk(32'h0C, 1, 1, 1, 1, 0, 2'b10, 5'd3);
        tab_rep[6]  = mk(32'h08, 0, 1, 0, 1, 1, 2'b01, 5'd2);
        tab_rep[7]  = mk(32'h08, 0, 1, 0, 0, 0, 2'b01, 5'd2);

        // Two-plus stall cycles with EX branch but bubble (no training),
        // held IF/ID snapshot resolving later, then flush during stall.
        tab_stl[0]  = mk(32'h08, 0, 0, 0, 0, 0, 2'b01, 5'd2);
        tab_stl[1]  = mk(32'h08, 0, 0, 0, 1, 1, 2'b01, 5'd2);
        tab_stl[2]  = mk(32'h08, 0, 0, 0, 1, 1, 2'b01, 5'd2);
        tab_stl[3]  = mk(32'h08, 0, 1, 0, 1, 1, 2'b01, 5'd2);
        tab_stl[4]  = mk(32'h08, 0, 1, 0, 1, 1, 2'b01, 5'd2);
        tab_stl[5]  = mk(32'h14, 0, 0, 1, 0, 0, 2'b10, 5'd5);
        tab_stl[6]  = mk(32'h14, 0, 1, 0, 0, 0, 2'b10, 5'd5);
        tab_stl[7]  = mk(32'h14, 0, 0, 0, 1, 0, 2'b10, 5'd5);
        tab_stl[8]  = mk(32'h14, 0, 1, 0, 0, 0, 2'b10, 5'd5);

        // After mid-run reset: read/write collision on idx 4, and a correctly
        // shifted branch resolving alongside a fetch shift (rule 2 applies).
        tab_col[0]  = mk(32'h10, 1, 1, 0, 0, 0, 2'b01, 5'd0);
        tab_col[1]  = mk(32'h10, 0, 1, 0, 0, 0, 2'b01, 5'd0);
        tab_col[2]  = mk(32'h10, 1, 1, 0, 1, 1, 2'b01, 5'd0);
        tab_col[3]  = mk(32'h10, 0, 1, 0, 1, 1, 2'b10, 5'd0);
        tab_col[4]  = mk(32'h14, 1, 1, 0, 1, 1, 2'b11, 5'd1);
        tab_col[5]  = mk(32'h1C, 0, 1, 0, 0, 0, 2'b11, 5'd3);

        // Reset state
        drive_idle();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check("reset_hold_pc0", 2'b01, 5'd0);
        current_pc = 32'h10;
        #1;
        check("reset_hold_pc10", 2'b01, 5'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) apply(tab_sat[i], $sformatf("sat[%0d]", i));

        reset_pulse();
        for (int i = 0; i < 8; i++) apply(tab_rep[i], $sformatf("repair[%0d]", i));
        for (int i = 0; i < 9; i++) apply(tab_stl[i], $sformatf("stall[%0d]", i));

        // Asynchronous reset mid-cycle with ghr=5 and pht[0]=10.
        @(negedge clk);
        drive_idle();
        #1;
        check("pre_async_reset", 2'b01, 5'd5);
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_now", 2'b01, 5'd0);
        @(negedge clk);
        #1;
        check("async_reset_held", 2'b01, 5'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) apply(tab_col[i], $sformatf("collide[%0d]", i));

        @(negedge clk);
        drive_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
